// File: rtl/psm_feeder_if.sv
// Operand-pair feeder bus: upstream push handshake, downstream PSM link and status.
interface psm_feeder_if;
  logic       In_Valid;
  logic [7:0] In_A;
  logic [7:0] In_B;
  logic       In_Ready;
  logic       Psm_Ready;
  logic       Start;
  logic [7:0] Din1;
  logic [7:0] Din2;
  logic [3:0] Count;
  logic [7:0] Done_Count;
  logic       Busy;
  logic       Err;

  // Environment side: operand source and processing state machine.
  modport master (
    output In_Valid, In_A, In_B, Psm_Ready,
    input  In_Ready, Start, Din1, Din2, Count, Done_Count, Busy, Err
  );

  // Feeder side.
  modport slave (
    input  In_Valid, In_A, In_B, Psm_Ready,
    output In_Ready, Start, Din1, Din2, Count, Done_Count, Busy, Err
  );
endinterface

// File: rtl/psm_feeder.sv
// Operand-pair FIFO feeding a downstream processing state machine (PSM).
// Pairs are queued, then issued one at a time with a one-cycle Start pulse;
// the feeder waits for the PSM to go busy and then idle again, counting
// completions and flagging a sticky error if the PSM never goes busy.
module psm_feeder #(
  parameter int unsigned DEPTH = 4
) (
  input logic         Clock,
  input logic         Reset,
  psm_feeder_if.slave bus
);

  localparam int unsigned PW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [7:0]    din1_q, din1_d;
  logic [7:0]    din2_q, din2_d;
  logic [7:0]    done_q, done_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          wb_seen_q, wb_seen_d;

  logic          in_ready;
  logic          push;
  logic          pop;

  // Full blocks pushes even when a pop happens the same cycle.
  assign in_ready = (count_q < DEPTH_C);
  assign push     = bus.In_Valid & in_ready;
  // Issue only from IDLE on registered occupancy, so a fresh entry waits one edge.
  assign pop      = (state_q == IDLE) && (count_q != '0) && bus.Psm_Ready;

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 4'd1;
    end else if (pop && !push) begin
      count_d = count_q - 4'd1;
    end
  end

  // Issue/handshake FSM next-state and registered outputs.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    din1_d    = din1_q;
    din2_d    = din2_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = done_q;
    err_d     = err_q;
    wb_seen_d = wb_seen_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d  = ISSUE;
          start_d  = 1'b1;
          din1_d   = mem_q[rd_ptr_q][15:8];
          din2_d   = mem_q[rd_ptr_q][7:0];
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT_BUSY;
        wb_seen_d = 1'b0;
      end
      WAIT_BUSY: begin
        if (!bus.Psm_Ready) begin
          state_d = WAIT_DONE;
        end else if (wb_seen_q) begin
          // Second edge with the PSM still idle: give up on this job.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wb_seen_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.Psm_Ready) begin
          done_d  = done_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers; reset discards the queue immediately.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      din1_q    <= '0;
      din2_q    <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      wb_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      din1_q    <= din1_d;
      din2_q    <= din2_d;
      done_q    <= done_d;
      start_q   <= start_d;
      err_q     <= err_d;
      wb_seen_q <= wb_seen_d;
    end
  end

  // Entry storage; contents are only meaningful behind the pointers.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.In_A, bus.In_B};
    end
  end

  assign bus.In_Ready   = in_ready;
  assign bus.Start      = start_q;
  assign bus.Din1       = din1_q;
  assign bus.Din2       = din2_q;
  assign bus.Count      = count_q;
  assign bus.Done_Count = done_q;
  assign bus.Err        = err_q;
  assign bus.Busy       = (count_q != '0) || (state_q != IDLE);

endmodule
